// File: rtl/mul_and_share_arbiter_if.sv
// Request/result bundle for the shared multiply-and-mask unit.
// The master side drives requests and result acceptance; the slave side is the arbiter.
interface mul_and_share_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 16
);
    localparam int unsigned TAG_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ*WIDTH-1:0] req_c;
    logic                     res_valid;
    logic                     res_ready;
    logic [WIDTH-1:0]         res_data;
    logic [TAG_W-1:0]         res_tag;
    logic                     busy;

    modport master (
        output req_valid, req_a, req_b, req_c, res_ready,
        input  req_ready, res_valid, res_data, res_tag, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_c, res_ready,
        output req_ready, res_valid, res_data, res_tag, busy
    );
endinterface

// File: rtl/mul_and_share_arbiter.sv
// Round-robin issue of NUM_REQ requesters into a shared three-stage (a*b)&c pipeline
// with a tagged, backpressured result port.
module mul_and_share_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    mul_and_share_arbiter_if.slave bus
);
    localparam int unsigned TAG_W = $clog2(NUM_REQ);

    logic             v1, v2, v3;
    logic [TAG_W-1:0] t1, t2, t3;
    logic [WIDTH-1:0] d1, d2, d3;
    logic [TAG_W-1:0] ptr;

    logic             advance;
    logic             any_valid;
    logic             issue;
    logic [TAG_W-1:0] grant;
    logic [TAG_W-1:0] cand;
    logic [WIDTH-1:0] a_sel, b_sel, c_sel;
    logic [WIDTH-1:0] prod;

    // The whole pipe moves as one; a stalled head freezes every stage and blocks issue.
    assign advance = !v3 || bus.res_ready;
    assign issue   = advance && any_valid;

    always_comb begin
        any_valid = 1'b0;
        grant     = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = TAG_W'((32'(ptr) + k) % NUM_REQ);
            if (!any_valid && bus.req_valid[cand]) begin
                any_valid = 1'b1;
                grant     = cand;
            end
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        c_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant == TAG_W'(i)) begin
                a_sel = bus.req_a[i*WIDTH +: WIDTH];
                b_sel = bus.req_b[i*WIDTH +: WIDTH];
                c_sel = bus.req_c[i*WIDTH +: WIDTH];
            end
        end
    end

    // Assigning to a WIDTH-bit result keeps only the low half of the product.
    assign prod = a_sel * b_sel;

    always_comb begin
        bus.req_ready = '0;
        if (rst_n && issue) begin
            bus.req_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1  <= 1'b0;
            v2  <= 1'b0;
            v3  <= 1'b0;
            t1  <= '0;
            t2  <= '0;
            t3  <= '0;
            d1  <= '0;
            d2  <= '0;
            d3  <= '0;
            ptr <= '0;
        end else if (advance) begin
            v1 <= issue;
            t1 <= issue ? grant : '0;
            d1 <= issue ? (prod & c_sel) : '0;
            v2 <= v1;
            t2 <= t1;
            d2 <= d1;
            v3 <= v2;
            t3 <= t2;
            d3 <= d2;
            if (issue) begin
                ptr <= (grant == TAG_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            end
        end
    end

    assign bus.res_valid = v3;
    assign bus.res_data  = d3;
    assign bus.res_tag   = t3;
    assign bus.busy      = v1 | v2 | v3;
endmodule

// File: tb/tb_mul_and_share_arbiter.sv
// Directed bench for mul_and_share_arbiter: operand vectors, round robin, stall,
// sparse traffic and mid-flight reset.
module tb_mul_and_share_arbiter;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned WIDTH   = 16;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic [15:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[4];
    logic [1:0] issued[16];

    always #5 clk = ~clk;

    mul_and_share_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

    mul_and_share_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 unit after the edge; checks happen 1 unit later, well before the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c);
        bus.req_a[i*WIDTH +: WIDTH] = a;
        bus.req_b[i*WIDTH +: WIDTH] = b;
        bus.req_c[i*WIDTH +: WIDTH] = c;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = '0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{a: 16'h0003, b: 16'h0005, c: 16'hFFFF, exp: 16'h000F};
        vecs[1] = '{a: 16'hFFFF, b: 16'hFFFF, c: 16'h00FF, exp: 16'h0001};
        vecs[2] = '{a: 16'h0100, b: 16'h0100, c: 16'hFFFF, exp: 16'h0000};
        vecs[3] = '{a: 16'h1234, b: 16'h0002, c: 16'h0F0F, exp: 16'h0408};

        rst_n = 1'b0;
        bus.req_valid = 4'hF;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_c = '0;
        bus.res_ready = 1'b1;
        tick();
        #1;
        check("reset req_ready", 32'(bus.req_ready), 0);
        check("reset res_valid", 32'(bus.res_valid), 0);
        check("reset res_data", 32'(bus.res_data), 0);
        check("reset res_tag", 32'(bus.res_tag), 0);
        check("reset busy", 32'(bus.busy), 0);
        rst_n = 1'b1;
        bus.req_valid = '0;
        tick();

        // Single ops from requester 0, one per table row.
        for (int v = 0; v < 4; v++) begin
            set_op(0, vecs[v].a, vecs[v].b, vecs[v].c);
            bus.req_valid = 4'b0001;
            #1;
            check("single req_ready", 32'(bus.req_ready), 32'h1);
            tick();
            bus.req_valid = '0;
            for (int s = 1; s <= 2; s++) begin
                #1;
                check("single busy mid", 32'(bus.busy), 1);
                check("single res_valid early", 32'(bus.res_valid), 0);
                tick();
            end
            #1;
            check("single res_valid", 32'(bus.res_valid), 1);
            check("single res_data", 32'(bus.res_data), 32'(vecs[v].exp));
            check("single res_tag", 32'(bus.res_tag), 0);
            check("single busy t+3", 32'(bus.busy), 1);
            tick();
            #1;
            check("single drained", 32'(bus.busy), 0);
        end

        // Round robin: all valid for 8 cycles, then only requester 2.
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, 16'(i + 1), 16'h0002, 16'hFFFF);
        for (int k = 0; k < 12; k++) begin
            logic [1:0] g;
            g = (k < 8) ? 2'(k % 4) : 2'd2;
            bus.req_valid = (k < 8) ? 4'hF : 4'b0100;
            #1;
            check("rr req_ready", 32'(bus.req_ready), 32'(1) << g);
            issued[k] = g;
            if (k >= 3) begin
                check("rr res_valid", 32'(bus.res_valid), 1);
                check("rr res_tag", 32'(bus.res_tag), 32'(issued[k-3]));
                check("rr res_data", 32'(bus.res_data), 2 * (32'(issued[k-3]) + 1));
            end else begin
                check("rr res_valid fill", 32'(bus.res_valid), 0);
            end
            tick();
        end
        bus.req_valid = '0;
        for (int k = 0; k < 3; k++) tick();
        #1;
        check("rr drained", 32'(bus.busy), 0);

        // Backpressure: ptr is 3 here, so grants run 3,0,1 before the stall.
        bus.req_valid = 4'hF;
        #1;
        check("bp grant 3", 32'(bus.req_ready), 32'h8);
        tick();
        check("bp grant 0", 32'(bus.req_ready), 32'h1);
        tick();
        check("bp grant 1", 32'(bus.req_ready), 32'h2);
        tick();
        bus.res_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            check("bp stall req_ready", 32'(bus.req_ready), 0);
            check("bp stall res_valid", 32'(bus.res_valid), 1);
            check("bp stall res_tag", 32'(bus.res_tag), 3);
            check("bp stall res_data", 32'(bus.res_data), 8);
            tick();
        end
        bus.res_ready = 1'b1;
        #1;
        check("bp ptr held grant 2", 32'(bus.req_ready), 32'h4);
        check("bp drain tag 3", 32'(bus.res_tag), 3);
        tick();
        bus.req_valid = '0;
        #1;
        check("bp drain valid 0", 32'(bus.res_valid), 1);
        check("bp drain tag 0", 32'(bus.res_tag), 0);
        check("bp drain data 0", 32'(bus.res_data), 2);
        tick();
        check("bp drain tag 1", 32'(bus.res_tag), 1);
        check("bp drain data 1", 32'(bus.res_data), 4);
        tick();
        check("bp drain tag 2", 32'(bus.res_tag), 2);
        check("bp drain data 2", 32'(bus.res_data), 6);
        tick();
        check("bp no duplicate", 32'(bus.res_valid), 0);
        check("bp idle", 32'(bus.busy), 0);

        // Sparse traffic from ptr=0.
        do_reset();
        bus.req_valid = 4'b1000;
        #1;
        check("sparse req3", 32'(bus.req_ready), 32'h8);
        tick();
        bus.req_valid = 4'b1010;
        #1;
        check("sparse ptr wrapped to 0", 32'(bus.req_ready), 32'h2);
        tick();
        #1;
        check("sparse ptr now 2", 32'(bus.req_ready), 32'h8);
        tick();
        bus.req_valid = '0;
        #1;
        check("sparse idle no grant", 32'(bus.req_ready), 0);
        tick();
        bus.req_valid = 4'hF;
        #1;
        check("sparse ptr held on idle", 32'(bus.req_ready), 32'h1);
        tick();

        // Reset with ops in flight.
        for (int k = 0; k < 2; k++) tick();
        rst_n = 1'b0;
        #1;
        check("midrst req_ready", 32'(bus.req_ready), 0);
        tick();
        #1;
        check("midrst res_valid", 32'(bus.res_valid), 0);
        check("midrst busy", 32'(bus.busy), 0);
        rst_n = 1'b1;
        bus.req_valid = 4'b1010;
        #1;
        check("midrst grant from ptr 0", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = '0;
        for (int s = 0; s < 2; s++) begin
            #1;
            check("midrst no stale result", 32'(bus.res_valid), 0);
            tick();
        end
        check("midrst new result", 32'(bus.res_valid), 1);
        check("midrst new tag", 32'(bus.res_tag), 1);
        check("midrst new data", 32'(bus.res_data), 4);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_and_share_arbiter.md
Name: mul_and_share_arbiter

Overview:
Shares one three-stage pipelined multiply-and-mask unit, p = (a*b) & c, among NUM_REQ requesters. A round-robin arbiter picks one request per cycle. The request's tag travels with its operands down the pipeline, and the result comes back on a single tagged output with valid/ready backpressure. This block is the issue/retire controller for the shared DSP-mapped datapath; the datapath stages are held inside the block.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 16, operand and result width
TAG_W, $clog2(NUM_REQ), tag width (derived; do not override)

Ports:
clk  in  1  clock; all logic on posedge
rst_n  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_a  in  NUM_REQ*WIDTH  operand a, requester i at [i*WIDTH +: WIDTH]
req_b  in  NUM_REQ*WIDTH  operand b, same packing
req_c  in  NUM_REQ*WIDTH  mask c, same packing
res_valid  out  1  result valid
res_ready  in  1  downstream accepts result
res_data  out  WIDTH  result
res_tag  out  TAG_W  index of the requester that issued this result
busy  out  1  any pipeline stage valid

Behaviour:
- Pipeline: stages S1/S2/S3, each holding a valid bit, a tag and data.
- S1 captures (a*b)[WIDTH-1:0] & c. The product is truncated to its low WIDTH bits before the AND.
- S2 copies S1 and S3 copies S2. res_valid = v3, res_data = d3, res_tag = t3.
- advance = !v3 || res_ready. When advance is 1, all stages shift. When it is 0, all stages hold. Bubbles are not collapsed.
- Latency: a handshake (req_valid[i] && req_ready[i]) in cycle t gives res_valid=1 in cycle t+3 if there is no stall. Each stall cycle adds 1.
- Throughput: 1 issue per cycle.
- Arbiter is round-robin with pointer ptr (TAG_W bits).
  - grant = the first i, searching ptr, ptr+1, … mod NUM_REQ, with req_valid[i]=1.
  - req_ready[i] = advance && any_valid && (grant==i). This is combinational from req_valid, ptr and v3/res_ready.
  - req_ready does not depend on req_a/b/c.
- On an accepted grant g: ptr <= (g+1) mod NUM_REQ. Otherwise ptr holds.
  - ptr does not move on a stalled cycle or when no request is valid.
- If advance=1 and no request is valid, S1 loads a bubble (v1=0).
- Stall with v3=1 and res_ready=0: res_data and res_tag stay stable, and no req_ready is asserted.
  - Requesters must hold their request; req_valid may drop, but it is not accepted.
- Simultaneous retire and issue in the same cycle (v3 && res_ready && grant) is legal and is full throughput.
- Reset (rst_n=0 at posedge):
  - v1..v3=0, all data/tag registers=0, ptr=0.
  - res_valid=0, res_data=0, res_tag=0, busy=0, req_ready=0 while rst_n=0.
- Reset mid-operation silently discards in-flight results; no result is emitted for them.
- busy = v1|v2|v3.
- Arithmetic is unsigned; the product's high half is discarded.

Test Plan:
- Single op, requester 0: a=3, b=5, c=0xFFFF accepted in cycle t -> res_valid in t+3, res_data=0x000F, res_tag=0. busy is high in t+1..t+3.
- Truncation and mask:
  - a=0xFFFF, b=0xFFFF, c=0x00FF -> 0x0001.
  - a=0x0100, b=0x0100, c=0xFFFF -> 0x0000.
  - a=0x1234, b=0x0002, c=0x0F0F -> 0x0408.
- Round robin: all 4 requesters valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3. res_tag sequence matches with no bubbles. Then only requester 2 valid -> granted every cycle.
- Backpressure: pipe full, res_ready=0 for 3 cycles -> res_data/res_tag held, req_ready all 0, ptr unchanged. res_ready=1 -> results drain in order with none lost or duplicated.
- Sparse traffic: requester 3 valid alone with ptr=0 -> granted, and ptr becomes 0. Next requester 1 alone -> granted, and ptr becomes 2.
- Reset mid-operation: three ops in flight, rst_n=0 for 1 cycle -> res_valid=0, busy=0, no stale results. The first request after release is granted starting from ptr=0.
